simd_lane_sequencer: RTL
========================

SIMD_LANE_SEQUENCER -- requirements
Module: simd_lane_sequencer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, lane operand/result width (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, max WAIT cycles per bit before error (>=1).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req_valid input 1, req_ready output 1: operation request handshake.
REQ-006 SHALL have ports req_op input 2 (0 ADD, 1 SUB, 2 MUL, 3 DIV), req_a input BIT_WIDTH, req_b input BIT_WIDTH.
REQ-007 SHALL have lane-drive outputs lane_start_op 1, lane_start_bit 1, lane_bit_select $clog2(BIT_WIDTH), lane_op_code 2, lane_a BIT_WIDTH, lane_b BIT_WIDTH.
REQ-008 SHALL have lane-return inputs lane_result BIT_WIDTH, lane_done_bit 1, lane_div_by_zero 1.
REQ-009 SHALL have ports rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-010 SHALL have outputs rsp_result BIT_WIDTH, rsp_dbz 1, rsp_err 1 (timeout), busy 1 (state != IDLE).

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, STEP, WAIT, RESP.
REQ-012 IDLE: req_ready=1, all else 0; on req_valid&&req_ready, latch req_op/a/b and go LOAD.
REQ-013 req_ready SHALL be 1 only in IDLE; requests in other states are not accepted.
REQ-014 lane_op_code/lane_a/lane_b SHALL be driven continuously from latched registers.
REQ-015 LOAD: lane_start_op=1 for exactly one cycle; clear bit counter cnt=0; go STEP.
REQ-016 STEP: lane_start_bit=1 for exactly one cycle, lane_bit_select=cnt; go WAIT.
REQ-017 WAIT: lane_start_bit=0; on lane_done_bit with cnt<BIT_WIDTH-1, cnt++ and go STEP.
REQ-018 WAIT: on lane_done_bit with cnt==BIT_WIDTH-1, capture lane_result into rsp_result, lane_div_by_zero into rsp_dbz, rsp_err=0, go RESP.
REQ-019 lane_done_bit outside WAIT SHALL be ignored.
REQ-020 lane_start_op and lane_start_bit SHALL never be asserted in the same cycle.
REQ-021 RESP: rsp_valid=1 with stable rsp_result/rsp_dbz/rsp_err until rsp_valid&&rsp_ready, then IDLE.
REQ-022 Latency with a lane returning done_bit the cycle after start_bit: rsp_valid asserts 2*BIT_WIDTH+2 cycles after the accept cycle (66 for BIT_WIDTH=32).
REQ-023 cnt SHALL not wrap; bits issued strictly 0..BIT_WIDTH-1 once each per operation.
REQ-024 Back-to-back: RESP->IDLE handshake and next request acceptance take separate cycles (one IDLE cycle minimum).

Reset
REQ-025 On reset_n low, asynchronously: state=IDLE, cnt=0, latched operands=0, rsp_result=0, rsp_dbz=0, rsp_err=0, all lane_* strobes 0, rsp_valid=0, busy=0; req_ready=1 after release.
REQ-026 Reset mid-operation SHALL abort it with no response; lane must be reset concurrently by the integrator.

Configuration
REQ-027 Macro SIMD_SEQ_TIMEOUT_EN defined: WAIT counts cycles without lane_done_bit; reaching TIMEOUT_CYCLES SHALL go RESP with rsp_err=1, rsp_result=0, rsp_dbz=0; counter clears on each STEP.
REQ-028 Macro undefined: no timeout counter, WAIT holds indefinitely, rsp_err tied 0.

Verification
REQ-029 BIT_WIDTH=32, real lane: ADD a=100 b=23 -> rsp_result=123, rsp_dbz=0, rsp_valid 66 cycles after accept.
REQ-030 SUB a=5 b=7 -> rsp_result=0xFFFFFFFE; lane_bit_select sequence 0..31 each exactly once, one start_op pulse.
REQ-031 DIV a=100 b=0 -> rsp_result=0xFFFFFFFF, rsp_dbz=1; then DIV 100/7 -> 14, rsp_dbz=0.
REQ-032 MUL 12*11 with rsp_ready low 10 cycles -> rsp_valid held, rsp_result=132 stable; req_ready=0 throughout; IDLE after handshake.
REQ-033 Assert reset_n low during WAIT at cnt=5 -> all outputs at reset values immediately; next ADD 1+1 -> 2.
REQ-034 SIMD_SEQ_TIMEOUT_EN, stub lane never asserts done_bit -> rsp_valid with rsp_err=1, rsp_result=0 exactly TIMEOUT_CYCLES WAIT cycles after first STEP.

Source files
------------

// File: rtl/simd_lane_sequencer.sv
// simd_lane_sequencer
//
// Purpose: accepts one arithmetic request (ADD/SUB/MUL/DIV) at a time and
// sequences a bit-serial SIMD lane through it. It issues one start_op pulse,
// then one start_bit pulse per bit index 0..BIT_WIDTH-1, waiting for the lane's
// done_bit after each. It captures the lane's final result and divide-by-zero
// flag and presents them on a valid/ready response port.
//
// Optional feature: define SIMD_SEQ_TIMEOUT_EN to add a per-bit WAIT timeout.
// When it expires, the sequencer responds with rsp_err=1, rsp_result=0 and
// rsp_dbz=0. Without the macro, WAIT holds indefinitely and rsp_err is tied 0.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake (ready only when idle)
//   req_op, req_a, req_b             operation (0 ADD, 1 SUB, 2 MUL, 3 DIV) and operands
//   lane_start_op, lane_start_bit    single-cycle strobes to the lane
//   lane_bit_select                  bit index of the current step
//   lane_op_code, lane_a, lane_b     latched operation, driven continuously
//   lane_result, lane_done_bit,
//   lane_div_by_zero                 lane return path
//   rsp_valid/rsp_ready              response handshake
//   rsp_result, rsp_dbz, rsp_err     response payload (rsp_err = timeout)
//   busy                             high whenever not idle
module simd_lane_sequencer #(
    parameter int unsigned BIT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_op,
    input  logic [BIT_WIDTH-1:0]         req_a,
    input  logic [BIT_WIDTH-1:0]         req_b,
    output logic                         lane_start_op,
    output logic                         lane_start_bit,
    output logic [$clog2(BIT_WIDTH)-1:0] lane_bit_select,
    output logic [1:0]                   lane_op_code,
    output logic [BIT_WIDTH-1:0]         lane_a,
    output logic [BIT_WIDTH-1:0]         lane_b,
    input  logic [BIT_WIDTH-1:0]         lane_result,
    input  logic                         lane_done_bit,
    input  logic                         lane_div_by_zero,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [BIT_WIDTH-1:0]         rsp_result,
    output logic                         rsp_dbz,
    output logic                         rsp_err,
    output logic                         busy
);

    localparam int unsigned    CntW    = $clog2(BIT_WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(BIT_WIDTH - 1);

    if (BIT_WIDTH < 2 || (BIT_WIDTH & (BIT_WIDTH - 1)) != 0) begin : g_bad_width
        $error("BIT_WIDTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {StIdle, StLoad, StStep, StWait, StResp} state_e;

    state_e                state_q,  state_d;
    logic [CntW-1:0]       cnt_q,    cnt_d;
    logic [1:0]            op_q,     op_d;
    logic [BIT_WIDTH-1:0]  a_q,      a_d;
    logic [BIT_WIDTH-1:0]  b_q,      b_d;
    logic [BIT_WIDTH-1:0]  result_q, result_d;
    logic                  dbz_q,    dbz_d;

`ifdef SIMD_SEQ_TIMEOUT_EN
    localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    logic [TmoW-1:0]       tmo_q,    tmo_d;
    logic                  err_q,    err_d;
`endif

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        dbz_d    = dbz_q;
`ifdef SIMD_SEQ_TIMEOUT_EN
        tmo_d    = tmo_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StStep;
            end
            StStep: begin
`ifdef SIMD_SEQ_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                // done_bit wins over a timeout that expires in the same cycle
                if (lane_done_bit) begin
                    if (cnt_q == LastBit) begin
                        result_d = lane_result;
                        dbz_d    = lane_div_by_zero;
`ifdef SIMD_SEQ_TIMEOUT_EN
                        err_d    = 1'b0;
`endif
                        state_d  = StResp;
                    end else begin
                        cnt_d   = cnt_q + CntW'(1);
                        state_d = StStep;
                    end
                end
`ifdef SIMD_SEQ_TIMEOUT_EN
                else if (tmo_q == TmoLast) begin
                    result_d = '0;
                    dbz_d    = 1'b0;
                    err_d    = 1'b1;
                    state_d  = StResp;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
`endif
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes and handshake outputs decoded from state
    always_comb begin
        req_ready       = 1'b0;
        lane_start_op   = 1'b0;
        lane_start_bit  = 1'b0;
        lane_bit_select = '0;
        rsp_valid       = 1'b0;
        busy            = (state_q != StIdle);
        unique case (state_q)
            StIdle: req_ready = 1'b1;
            StLoad: lane_start_op = 1'b1;
            StStep: begin
                lane_start_bit  = 1'b1;
                lane_bit_select = cnt_q;
            end
            StWait: lane_bit_select = cnt_q;
            StResp: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign lane_op_code = op_q;
    assign lane_a       = a_q;
    assign lane_b       = b_q;
    assign rsp_result   = result_q;
    assign rsp_dbz      = dbz_q;
`ifdef SIMD_SEQ_TIMEOUT_EN
    assign rsp_err      = err_q;
`else
    assign rsp_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
`ifdef SIMD_SEQ_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
`ifdef SIMD_SEQ_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

endmodule
